rs_latch_driver: RTL and testbench
==================================

Name: rs_latch_driver

Overview:
Upstream drive stage for the gate-level RS_latch. Turns two noisy request lines into clean, mutually exclusive, fixed-width set/reset pulses. Each pulse is followed by a dead time so the latch settles before any further drive. The block's set/reset outputs connect directly to the latch's set/reset inputs.

Parameters:
PULSE_CYCLES, 4, width of each set/reset pulse in clk cycles (>=1)
GAP_CYCLES, 2, dead time after each pulse with both outputs low (>=1)
DEBOUNCE_CYCLES, 8, consecutive stable samples required to accept a level change (>=1)
CNT_W, 8, width of internal counters; all cycle parameters must be < 2**CNT_W

Ports:
clk  in  1  single clock, rising-edge
rst_n  in  1  asynchronous, active-low reset
set_req  in  1  raw set request, may bounce
reset_req  in  1  raw reset request, may bounce
set  out  1  registered pulse to latch set input
reset  out  1  registered pulse to latch reset input
busy  out  1  high while a pulse or gap is in progress, or a command is pending
conflict  out  1  one-cycle strobe: a set command was discarded in favour of reset

Behaviour:
- Reset: set=0, reset=0, busy=0, conflict=0, FSM=IDLE, pending flags=0, debounced levels=0, all counters=0. Assertion is immediate (async); release is synchronous to the next clk edge.
- Debounce (per line):
  - Counter counts consecutive samples that differ from the debounced level; any matching sample clears it.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips on that edge.
- Command generation:
  - A debounced rising edge produces one command. Falling edges produce none, so holding a request high yields exactly one pulse.
  - A command sets a pending flag; a second same-type command while pending is merged (no queueing depth beyond 1).
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE: pending reset -> RST_P; else pending set -> SET_P. The consumed flag clears.
  - SET_P / RST_P: corresponding output high for exactly PULSE_CYCLES, then -> GAP.
  - GAP: both outputs low for exactly GAP_CYCLES, then -> IDLE.
- Latency: raw input sampled high at edges 1..D (D=DEBOUNCE_CYCLES) -> set/reset first high after edge D+2, i.e. debounce + 1 cycle edge-detect + 1 cycle dispatch.
- Priority and simultaneity:
  - Reset wins. If both pending flags are set when IDLE dispatches, reset is issued, the set flag is cleared and conflict strobes for 1 cycle.
  - The same applies when both debounced edges arrive in the same cycle.
- Invariant: set & reset is never 1 on any cycle, including the reset-release edge.
- Commands arriving during SET_P/RST_P/GAP are held pending and dispatched on the first IDLE cycle.
- Mid-operation reset: an active pulse truncates immediately and pending commands are lost. A request still held high after release is re-debounced from level 0 and issues a new command.

Optional Feature:
Macro RS_DRV_SYNC_EN.
- Defined: each raw request passes through a 2-flop synchroniser before the debouncer; latency grows by 2 cycles (first output at edge D+4).
- Undefined: requests feed the debouncer directly and are assumed synchronous to clk.

Decomposition:
- Package rs_drv_pkg holds:
  - FSM state encoding (IDLE=2'd0, SET_P=2'd1, RST_P=2'd2, GAP=2'd3)
  - default constants for PULSE_CYCLES, GAP_CYCLES, DEBOUNCE_CYCLES, CNT_W
- One natural sub-module, rs_debounce (optional synchroniser, counter, debounced level, rising-edge strobe), instantiated twice.

Test Plan:
- Clean set_req held high 20 cycles (defaults) -> set high for exactly 4 cycles starting after edge 10, then 2 gap cycles, busy low after; only one pulse.
- set_req toggling every 3 cycles for 30 cycles (D=8) -> no command, set/reset stay 0, busy stays 0.
- set_req and reset_req rise on the same cycle, held 20 cycles -> one reset pulse of 4 cycles, conflict strobes once, no set pulse.
- reset_req debounced while a set pulse is in its 2nd cycle -> set completes 4 cycles, 2 gap cycles, then reset high 4 cycles; no overlap.
- rst_n driven low during the 3rd cycle of a set pulse -> set drops to 0 asynchronously, busy=0. After release with set_req still high -> new pulse after a fresh 8-cycle debounce.
- RS_DRV_SYNC_EN defined, repeat the first scenario -> set pulse first high after edge 12, width 4.

Source files
------------

// File: rtl/rs_drv_pkg.sv
// Shared types and default constants for the RS-latch drive stage.
// Optional 2-flop request synchroniser is enabled with RS_DRV_SYNC_EN.
package rs_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } drv_state_e;

  localparam int DEF_PULSE_CYCLES    = 4;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/rs_debounce.sv
// One request line: optional synchroniser (RS_DRV_SYNC_EN), debouncer and
// a one-cycle strobe on each accepted rising edge.
module rs_debounce
  import rs_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);

  logic             sample;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef RS_DRV_SYNC_EN
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  assign sample = sync_q;
`else
  assign sample = raw_i;
`endif

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sample != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rs_latch_driver.sv
// Drives an RS latch with clean, mutually exclusive set/reset pulses plus dead time.
// Define RS_DRV_SYNC_EN to synchronise the raw requests (adds 2 cycles of latency).
module rs_latch_driver
  import rs_drv_pkg::*;
#(
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic reset_req,
  output logic set,
  output logic reset,
  output logic busy,
  output logic conflict
);

  logic             set_rise, rst_rise;
  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_set_q, pend_set_d;
  logic             pend_rst_q, pend_rst_d;
  logic             clr_set, clr_rst;
  logic             set_q, set_d;
  logic             reset_q, reset_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;

  rs_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (set_req),
    .rise_o (set_rise)
  );

  rs_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_rst_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (reset_req),
    .rise_o (rst_rise)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_set    = 1'b0;
    clr_rst    = 1'b0;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Reset has priority; a set waiting alongside it is dropped.
        if (pend_rst_q) begin
          state_d    = RST_P;
          clr_rst    = 1'b1;
          clr_set    = 1'b1;
          conflict_d = pend_set_q;
        end else if (pend_set_q) begin
          state_d = SET_P;
          clr_set = 1'b1;
        end
      end
      SET_P, RST_P: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A fresh edge arriving on the dispatch cycle stays pending as a new command.
    pend_set_d = (pend_set_q & ~clr_set) | set_rise;
    pend_rst_d = (pend_rst_q & ~clr_rst) | rst_rise;

    // Outputs are decoded from the single next state, so set and reset cannot overlap.
    set_d   = (state_d == SET_P);
    reset_d = (state_d == RST_P);
    busy_d  = (state_d != IDLE) | pend_set_d | pend_rst_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_set_q <= 1'b0;
      pend_rst_q <= 1'b0;
      set_q      <= 1'b0;
      reset_q    <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_set_q <= pend_set_d;
      pend_rst_q <= pend_rst_d;
      set_q      <= set_d;
      reset_q    <= reset_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign set      = set_q;
  assign reset    = reset_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Bench for rs_latch_driver: directed scenarios plus random bouncy requests,
// checked cycle by cycle against a timeline model (honours RS_DRV_SYNC_EN).
module tb_rs_latch_driver;

  localparam int P = 4;
  localparam int G = 2;
  localparam int D = 8;

  logic clk;
  logic rst_n;
  logic set_req;
  logic reset_req;
  logic set;
  logic reset;
  logic busy;
  logic conflict;

  int n_checks = 0;
  int n_fail   = 0;

  rs_latch_driver #(
    .PULSE_CYCLES    (P),
    .GAP_CYCLES      (G),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .reset_req (reset_req),
    .set       (set),
    .reset     (reset),
    .busy      (busy),
    .conflict  (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 = set line, index 1 = reset line.
  int       m_run  [2];
  bit       m_lvl  [2];
  bit       m_rise [2];
  bit       m_pend [2];
  bit       m_sy1  [2];
  bit       m_sy2  [2];
  bit [1:0] m_sched [$];   // future {reset,set} outputs, one entry per edge
  bit       e_set, e_rst, e_busy, e_conf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_lvl[i] = 0; m_rise[i] = 0; m_pend[i] = 0;
      m_sy1[i] = 0; m_sy2[i] = 0;
    end
    m_sched.delete();
    e_set = 0; e_rst = 0; e_busy = 0; e_conf = 0;
  endtask

  task model_step(input bit s_in, input bit r_in);
    bit       smp [2];
    bit       inp [2];
    bit [1:0] o;
    bit [1:0] code;
    inp[0] = s_in;
    inp[1] = r_in;
`ifdef RS_DRV_SYNC_EN
    for (int i = 0; i < 2; i++) begin
      smp[i]   = m_sy2[i];
      m_sy2[i] = m_sy1[i];
      m_sy1[i] = inp[i];
    end
`else
    smp = inp;
`endif
    e_conf = 0;
    code   = 2'b00;
    if (m_sched.size() > 0) begin
      o = m_sched.pop_front();
    end else begin
      if (m_pend[1]) begin
        code      = 2'b10;
        e_conf    = m_pend[0];
        m_pend[0] = 0;
        m_pend[1] = 0;
      end else if (m_pend[0]) begin
        code      = 2'b01;
        m_pend[0] = 0;
      end
      if (code != 2'b00) begin
        for (int k = 0; k < P; k++) m_sched.push_back(code);
        for (int k = 0; k < G + 1; k++) m_sched.push_back(2'b00);
        o = m_sched.pop_front();
      end else begin
        o = 2'b00;
      end
    end
    e_set = o[0];
    e_rst = o[1];
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = m_pend[i] | m_rise[i];
      m_rise[i] = 0;
      if (smp[i] == m_lvl[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i]  = ~m_lvl[i];
          m_rise[i] = m_lvl[i];
          m_run[i]  = 0;
        end
      end
    end
    e_busy = (m_sched.size() > 0) || m_pend[0] || m_pend[1];
  endtask

  task automatic check_outs();
    chk("set", 32'(set), 32'(e_set));
    chk("reset", 32'(reset), 32'(e_rst));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("conflict", 32'(conflict), 32'(e_conf));
    chk("exclusive", 32'(set & reset), 32'd0);
  endtask

  task automatic cyc(input bit s, input bit r);
    @(negedge clk);
    rst_n     = 1'b1;
    set_req   = s;
    reset_req = r;
    @(posedge clk);
    model_step(s, r);
    #1;
    check_outs();
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  int hold [2];
  bit rval [2];

  initial begin
    rst_n     = 1'b0;
    set_req   = 1'b0;
    reset_req = 1'b0;
    do_reset();

    // Clean set request held high.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    idle_cycles(25);

    // Bouncing request, never stable long enough.
    for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 0, 1'b0);
    idle_cycles(25);

    // Simultaneous requests: reset wins, conflict strobes.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
    idle_cycles(25);

    // Reset request lands during the set pulse.
    for (int i = 0; i < 30; i++) cyc(1'b1, i >= 3);
    idle_cycles(25);

    // Reset during the third set cycle, request still held afterwards.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 25; i++) cyc(1'b1, 1'b0);
    idle_cycles(25);

    // Random bouncy requests with occasional mid-operation resets.
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          rval[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 14));
        end
        hold[i]--;
      end
      cyc(rval[0], rval[1]);
      if ($urandom_range(0, 249) == 0) do_reset();
    end
    idle_cycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
